// File: rtl/seq_serializer.sv
// Parallel-in, serial-out stage feeding the sequence detector: WIDTH-bit words in via
// valid/ready, MSB-first bits out framed by dout_valid/dout_last. Optional macro SER_PARITY_EN
// appends an even-parity bit to every frame.
module seq_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic             busy
);

`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [FRAME-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q, dout_last_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             shift_on;

    // The whole frame, including the optional parity bit, is loaded at once so the
    // shift register MSB is always the bit to present next.
    function automatic logic [FRAME-1:0] load_word(input logic [WIDTH-1:0] word);
`ifdef SER_PARITY_EN
        return {word, ^word};
`else
        return word;
`endif
    endfunction

    assign load_ready = (state_q == ST_IDLE) ||
                        ((state_q == ST_SHIFT) && (cnt_q == CNT_LAST));
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shreg_d = load_word(data_in);
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    if (accept) begin
                        shreg_d = load_word(data_in);
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    shreg_d = {shreg_q[FRAME-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase

        // Outputs are computed from next state so they can be registered without lag.
        shift_on     = (state_d == ST_SHIFT);
        dout_d       = shift_on && shreg_d[FRAME-1];
        dout_valid_d = shift_on;
        dout_last_d  = shift_on && (cnt_d == CNT_LAST);
        busy_d       = shift_on;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            busy_q       <= busy_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed table-driven bench for seq_serializer (WIDTH=8); expected rows are built per cycle
// from hand-chosen words, plus a bounded hand-written frame capture at the end.
module tb_seq_serializer;

    localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             dout;
    logic             dout_valid;
    logic             dout_last;
    logic             busy;

    seq_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One record per clock: inputs held for the cycle, outputs expected before its edge.
    // exp = {dout, dout_valid, dout_last, busy, load_ready}
    typedef struct {
        logic             rst;
        logic             lv;
        logic [WIDTH-1:0] din;
        logic [4:0]       exp;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic v(input logic r, input logic lv, input logic [WIDTH-1:0] din,
                     input logic e_dout, input logic e_dv, input logic e_dl,
                     input logic e_busy, input logic e_rdy);
        vec_t t;
        t.rst = r;
        t.lv  = lv;
        t.din = din;
        t.exp = {e_dout, e_dv, e_dl, e_busy, e_rdy};
        vq.push_back(t);
    endtask

    // Rows for one full frame of `word`; lv_mask[i] drives load_valid on row i with `din`.
    task automatic frame(input logic [WIDTH-1:0] word, input logic [FRAME-1:0] lv_mask,
                         input logic [WIDTH-1:0] din);
        logic b;
        logic last;
        for (int i = 0; i < FRAME; i++) begin
            b    = (i < WIDTH) ? word[WIDTH-1-i] : ^word;
            last = (i == FRAME - 1);
            v(1'b0, lv_mask[i], lv_mask[i] ? din : 8'hAA, b, 1'b1, last, 1'b1, last);
        end
    endtask

    logic [FRAME-1:0] all_ones;
    logic [FRAME-1:0] last_only;
    logic [FRAME-1:0] hold_mask;
    logic [15:0]      acc;
    int               ncyc;
    bit               got_last;

    initial begin
        all_ones  = '1;
        last_only = '0;
        last_only[FRAME-1] = 1'b1;
        hold_mask = last_only;
        for (int i = 1; i <= 5; i++) hold_mask[i] = 1'b1;

        // Reset with load_valid high and all-ones data: nothing may be accepted.
        v(1, 1, 8'hFF, 0, 0, 0, 0, 1);
        v(1, 1, 8'hFF, 0, 0, 0, 0, 1);
        v(0, 0, 8'h00, 0, 0, 0, 0, 1);
        // Single word then back-to-back with load_valid held through the first frame.
        v(0, 1, 8'hA5, 0, 0, 0, 0, 1);
        frame(8'hA5, all_ones, 8'h3C);
        frame(8'h3C, '0, 8'h00);
        v(0, 0, 8'h00, 0, 0, 0, 0, 1);
        // load_valid asserted mid-frame with 8'h0F: only the last-bit edge takes it.
        v(0, 1, 8'h55, 0, 0, 0, 0, 1);
        frame(8'h55, hold_mask, 8'h0F);
        frame(8'h0F, '0, 8'h00);
        v(0, 0, 8'h00, 0, 0, 0, 0, 1);
        // Reset on the third bit of 8'hFF, then 8'h81 serializes cleanly.
        v(0, 1, 8'hFF, 0, 0, 0, 0, 1);
        v(0, 0, 8'hAA, 1, 1, 0, 1, 0);
        v(0, 0, 8'hAA, 1, 1, 0, 1, 0);
        v(1, 1, 8'hAA, 1, 1, 0, 1, 0);
        v(0, 1, 8'h81, 0, 0, 0, 0, 1);
        frame(8'h81, '0, 8'h00);
        v(0, 0, 8'h00, 0, 0, 0, 0, 1);
        // Words whose parity differs (1 for 8'h07, 0 for 8'h03 when parity is enabled).
        v(0, 1, 8'h07, 0, 0, 0, 0, 1);
        frame(8'h07, last_only, 8'h03);
        frame(8'h03, '0, 8'h00);
        v(0, 0, 8'h00, 0, 0, 0, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            rst        = vq[i].rst;
            load_valid = vq[i].lv;
            data_in    = vq[i].din;
            @(negedge clk);
            check($sformatf("row%0d", i),
                  {27'd0, dout, dout_valid, dout_last, busy, load_ready}, {27'd0, vq[i].exp});
            @(posedge clk);
            #1;
        end

        // Capture a whole frame of 8'hC3 with a bounded wait on dout_last.
        rst        = 1'b0;
        load_valid = 1'b1;
        data_in    = 8'hC3;
        @(negedge clk);
        check("cap_ready", {31'd0, load_ready}, 32'd1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        data_in    = 8'hFF;
        acc        = '0;
        ncyc       = 0;
        got_last   = 1'b0;
        while (!got_last && ncyc < 40) begin
            @(negedge clk);
            ncyc++;
            if (dout_valid) acc = {acc[14:0], dout};
            if (dout_last) got_last = 1'b1;
        end
        check("cap_last_seen", {31'd0, got_last}, 32'd1);
        check("cap_frame_len", ncyc, FRAME);
        check("cap_data", {16'd0, acc >> (FRAME - WIDTH)}, 32'h0000_00C3);
        @(negedge clk);
        check("cap_idle_after", {29'd0, dout_valid, busy, load_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
